// File: rtl/wb_sys_pkg.sv
// ---------------------------------------------------------------------------
// wb_sys_pkg
// Shared constants and types for the writeback / system-call unit:
//   - SYSCALL service codes carried in $v0
//   - console event kind encoding driven on cons_kind
//   - instruction fields that identify a SYSCALL encoding
// ---------------------------------------------------------------------------
package wb_sys_pkg;

    // Service codes as they appear in $v0 (full 32-bit compare).
    localparam logic [31:0] SC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SC_PRINT_STR  = 32'd4;
    localparam logic [31:0] SC_EXIT       = 32'd10;
    localparam logic [31:0] SC_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SC_EXIT2      = 32'd17;
    localparam logic [31:0] SC_PRINT_HEX  = 32'd34;

    // SYSCALL is an R-type (SPECIAL opcode) with funct 0x0C.
    localparam logic [5:0] OPC_SPECIAL   = 6'h00;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

    // Kind of console event reported alongside cons_data.
    typedef enum logic [1:0] {
        KIND_INT  = 2'd0,
        KIND_STR  = 2'd1,
        KIND_CHAR = 2'd2,
        KIND_HEX  = 2'd3
    } cons_kind_e;

    // True when the instruction word is a SYSCALL encoding.
    function automatic logic is_syscall_insn(input logic [31:0] insn);
        return (insn[31:26] == OPC_SPECIAL) && (insn[5:0] == FUNCT_SYSCALL);
    endfunction

endpackage

// File: rtl/wb_result_mux.sv
// ---------------------------------------------------------------------------
// wb_result_mux
// MemToReg result select for the writeback stage.
// Ports:
//   sel        in   1       1 selects read_data, 0 selects alu_out
//   read_data  in   DATA_W  data-memory read data
//   alu_out    in   DATA_W  ALU result
//   result     out  DATA_W  selected write-back value
// ---------------------------------------------------------------------------
module wb_result_mux #(
    parameter int DATA_W = 32
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] result
);

    assign result = sel ? read_data : alu_out;

endmodule

// File: rtl/wb_syscall_unit.sv
// ---------------------------------------------------------------------------
// wb_syscall_unit
// Writeback stage of the pipelined MIPS core plus a clocked system-call unit.
// The write-back value is chosen by the MemToReg mux and fanned out, together
// with the destination register, to the register file and forwarding paths.
// A SYSCALL reaching writeback is decoded from $v0/$a0 into console events,
// a sticky halt with exit code, a sticky error flag and an accept counter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_to_reg_w             result select (1 = read_data_w)
//   read_data_w, alu_out_w   mux data inputs
//   write_reg_w              destination register index
//   a0, v0                   syscall argument / service code
//   instruction_in           instruction currently in writeback
//   syscall_in               control-unit syscall flag
//   write_reg_w_out/_regs    destination copies (hazard unit / register file)
//   result_w, result_w_fwd,
//   result_w_fwd_mm          mux result and its EX / MEM forwarding copies
//   cons_valid/kind/data     one-cycle console event and its payload
//   halt, exit_code          sticky program exit and status
//   sc_error                 sticky unsupported-code flag
//   sc_count                 saturating count of accepted syscalls
// ---------------------------------------------------------------------------
module wb_syscall_unit
    import wb_sys_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_to_reg_w,
    input  logic [DATA_W-1:0] read_data_w,
    input  logic [DATA_W-1:0] alu_out_w,
    input  logic [REG_W-1:0]  write_reg_w,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] v0,
    input  logic [31:0]       instruction_in,
    input  logic              syscall_in,
    output logic [REG_W-1:0]  write_reg_w_out,
    output logic [DATA_W-1:0] result_w,
    output logic [DATA_W-1:0] result_w_fwd,
    output logic [REG_W-1:0]  write_reg_w_regs,
    output logic [DATA_W-1:0] result_w_fwd_mm,
    output logic              cons_valid,
    output logic [1:0]        cons_kind,
    output logic [31:0]       cons_data,
    output logic              halt,
    output logic [31:0]       exit_code,
    output logic              sc_error,
    output logic [CNT_W-1:0]  sc_count
);

    // ------------------------------------------------------------------
    // Result mux and fan-out (purely combinational)
    // ------------------------------------------------------------------
    wb_result_mux #(
        .DATA_W (DATA_W)
    ) u_result_mux (
        .sel       (mem_to_reg_w),
        .read_data (read_data_w),
        .alu_out   (alu_out_w),
        .result    (result_w)
    );

    assign result_w_fwd     = result_w;
    assign result_w_fwd_mm  = result_w;
    assign write_reg_w_out  = write_reg_w;
    assign write_reg_w_regs = write_reg_w;

    // ------------------------------------------------------------------
    // System-call unit
    // ------------------------------------------------------------------
    logic        accept;
    logic [31:0] code;
    logic [31:0] arg;

    // The syscall logic is defined on 32-bit registers.
    assign code = 32'(v0);
    assign arg  = 32'(a0);

    // Once halted the core is finished: later syscalls are fully ignored.
    assign accept = syscall_in && is_syscall_insn(instruction_in) && !halt;

    // NOTE: state registers use non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cons_valid <= 1'b0;
            cons_kind  <= KIND_INT;
            cons_data  <= '0;
            halt       <= 1'b0;
            exit_code  <= '0;
            sc_error   <= 1'b0;
            sc_count   <= '0;
        end else begin
            // Strobe by default; kind/data keep the last event's payload.
            cons_valid <= 1'b0;

            if (accept) begin
                if (sc_count != {CNT_W{1'b1}}) begin
                    sc_count <= sc_count + CNT_W'(1);
                end

                case (code)
                    SC_PRINT_INT: begin
                        cons_valid <= 1'b1;
                        cons_kind  <= KIND_INT;
                        cons_data  <= arg;
                    end
                    SC_PRINT_STR: begin
                        cons_valid <= 1'b1;
                        cons_kind  <= KIND_STR;
                        cons_data  <= arg;
                    end
                    SC_PRINT_CHAR: begin
                        cons_valid <= 1'b1;
                        cons_kind  <= KIND_CHAR;
                        cons_data  <= {24'b0, arg[7:0]};
                    end
                    SC_PRINT_HEX: begin
                        cons_valid <= 1'b1;
                        cons_kind  <= KIND_HEX;
                        cons_data  <= arg;
                    end
                    SC_EXIT: begin
                        halt      <= 1'b1;
                        exit_code <= '0;
                    end
                    SC_EXIT2: begin
                        halt      <= 1'b1;
                        exit_code <= arg;
                    end
                    default: begin
                        sc_error <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_syscall_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_syscall_unit
// Self-checking bench for wb_syscall_unit. Each scenario task drives one
// cycle of stimulus and pushes the registered outputs it requires for the
// following cycle onto a scoreboard queue; the queue is popped and compared
// one cycle later, #1 after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_syscall_unit;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    localparam logic [31:0] INSN_SYSCALL = 32'h0000000C;

    logic              clk;
    logic              rst;
    logic              mem_to_reg_w;
    logic [DATA_W-1:0] read_data_w;
    logic [DATA_W-1:0] alu_out_w;
    logic [REG_W-1:0]  write_reg_w;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] v0;
    logic [31:0]       instruction_in;
    logic              syscall_in;
    logic [REG_W-1:0]  write_reg_w_out;
    logic [DATA_W-1:0] result_w;
    logic [DATA_W-1:0] result_w_fwd;
    logic [REG_W-1:0]  write_reg_w_regs;
    logic [DATA_W-1:0] result_w_fwd_mm;
    logic              cons_valid;
    logic [1:0]        cons_kind;
    logic [31:0]       cons_data;
    logic              halt;
    logic [31:0]       exit_code;
    logic              sc_error;
    logic [CNT_W-1:0]  sc_count;

    wb_syscall_unit #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_to_reg_w     (mem_to_reg_w),
        .read_data_w      (read_data_w),
        .alu_out_w        (alu_out_w),
        .write_reg_w      (write_reg_w),
        .a0               (a0),
        .v0               (v0),
        .instruction_in   (instruction_in),
        .syscall_in       (syscall_in),
        .write_reg_w_out  (write_reg_w_out),
        .result_w         (result_w),
        .result_w_fwd     (result_w_fwd),
        .write_reg_w_regs (write_reg_w_regs),
        .result_w_fwd_mm  (result_w_fwd_mm),
        .cons_valid       (cons_valid),
        .cons_kind        (cons_kind),
        .cons_data        (cons_data),
        .halt             (halt),
        .exit_code        (exit_code),
        .sc_error         (sc_error),
        .sc_count         (sc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        cv;
        logic [1:0]  kind;
        logic [31:0] data;
        logic        halt;
        logic [31:0] exit_code;
        logic        err;
        logic [15:0] cnt;
    } sc_obs_t;

    sc_obs_t sb[$];
    int      vectors     = 0;
    int      miscompares = 0;

    // Queue the registered state required after the next rising edge.
    task automatic expect_next(input logic cv, input logic [1:0] kind,
                               input logic [31:0] data, input logic h,
                               input logic [31:0] ec, input logic err,
                               input logic [15:0] cnt);
        sb.push_back('{cv: cv, kind: kind, data: data, halt: h,
                       exit_code: ec, err: err, cnt: cnt});
    endtask

    // Advance one clock and compare the DUT against the oldest expectation.
    task automatic clock_and_score(input string name);
        sc_obs_t exp_v;
        sc_obs_t obs;
        @(posedge clk);
        #1;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, nothing to compare", name);
        end else begin
            exp_v = sb.pop_front();
            obs = '{cv: cons_valid, kind: cons_kind, data: cons_data,
                    halt: halt, exit_code: exit_code, err: sc_error,
                    cnt: sc_count};
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL %s: got cv=%b kind=%0d data=%h halt=%b exit=%h err=%b cnt=%h, want cv=%b kind=%0d data=%h halt=%b exit=%h err=%b cnt=%h",
                         name, obs.cv, obs.kind, obs.data, obs.halt,
                         obs.exit_code, obs.err, obs.cnt, exp_v.cv,
                         exp_v.kind, exp_v.data, exp_v.halt,
                         exp_v.exit_code, exp_v.err, exp_v.cnt);
            end
        end
    endtask

    task automatic drive_sys(input logic [31:0] code, input logic [31:0] arg,
                             input logic [31:0] insn, input logic flag);
        v0             = code;
        a0             = arg;
        instruction_in = insn;
        syscall_in     = flag;
    endtask

    task automatic drive_idle();
        syscall_in     = 1'b0;
        instruction_in = 32'h00000000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        expect_next(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0);
        clock_and_score("reset");
        rst = 1'b0;
    endtask

    task automatic test_mux();
        mem_to_reg_w = 1'b0;
        alu_out_w    = 32'h00001234;
        read_data_w  = 32'h0000ABCD;
        write_reg_w  = 5'd9;
        #1;
        vectors++;
        if ({result_w, result_w_fwd, result_w_fwd_mm} !== {3{32'h00001234}}) begin
            miscompares++;
            $display("FAIL mux_alu: got %h/%h/%h want 00001234", result_w,
                     result_w_fwd, result_w_fwd_mm);
        end
        vectors++;
        if ({write_reg_w_out, write_reg_w_regs} !== {5'd9, 5'd9}) begin
            miscompares++;
            $display("FAIL mux_reg: got %0d/%0d want 9", write_reg_w_out,
                     write_reg_w_regs);
        end
        mem_to_reg_w = 1'b1;
        write_reg_w  = 5'd31;
        #1;
        vectors++;
        if ({result_w, result_w_fwd, result_w_fwd_mm} !== {3{32'h0000ABCD}}) begin
            miscompares++;
            $display("FAIL mux_mem: got %h/%h/%h want 0000abcd", result_w,
                     result_w_fwd, result_w_fwd_mm);
        end
        vectors++;
        if ({write_reg_w_out, write_reg_w_regs} !== {5'd31, 5'd31}) begin
            miscompares++;
            $display("FAIL mux_reg31: got %0d/%0d want 31", write_reg_w_out,
                     write_reg_w_regs);
        end
    endtask

    // print int, print char, non-SYSCALL encodings, exit with code, lock-out
    task automatic test_print_and_exit();
        drive_sys(32'd1, 32'hFFFFFFFF, INSN_SYSCALL, 1'b1);
        expect_next(1'b1, 2'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 16'd1);
        clock_and_score("print_int");
        drive_idle();
        expect_next(1'b0, 2'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 16'd1);
        clock_and_score("print_int_strobe_end");

        drive_sys(32'd11, 32'h00000141, INSN_SYSCALL, 1'b1);
        expect_next(1'b1, 2'd2, 32'h00000041, 1'b0, 32'h0, 1'b0, 16'd2);
        clock_and_score("print_char");

        drive_sys(32'd11, 32'h00000141, 32'h0000000D, 1'b1);
        expect_next(1'b0, 2'd2, 32'h00000041, 1'b0, 32'h0, 1'b0, 16'd2);
        clock_and_score("bad_funct");
        drive_sys(32'd11, 32'h00000141, 32'h0400000C, 1'b1);
        expect_next(1'b0, 2'd2, 32'h00000041, 1'b0, 32'h0, 1'b0, 16'd2);
        clock_and_score("bad_opcode");
        drive_sys(32'd11, 32'h00000141, INSN_SYSCALL, 1'b0);
        expect_next(1'b0, 2'd2, 32'h00000041, 1'b0, 32'h0, 1'b0, 16'd2);
        clock_and_score("no_flag");

        drive_sys(32'd17, 32'd7, INSN_SYSCALL, 1'b1);
        expect_next(1'b0, 2'd2, 32'h00000041, 1'b1, 32'd7, 1'b0, 16'd3);
        clock_and_score("exit2");
        drive_sys(32'd1, 32'h5555AAAA, INSN_SYSCALL, 1'b1);
        expect_next(1'b0, 2'd2, 32'h00000041, 1'b1, 32'd7, 1'b0, 16'd3);
        clock_and_score("halted_ignore");
        drive_sys(32'd99, 32'h0, INSN_SYSCALL, 1'b1);
        expect_next(1'b0, 2'd2, 32'h00000041, 1'b1, 32'd7, 1'b0, 16'd3);
        clock_and_score("halted_ignore_bad");

        drive_idle();
        rst = 1'b1;
        expect_next(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0);
        clock_and_score("reset_after_halt");
        rst = 1'b0;
    endtask

    // unsupported codes (incl. upper bits), string, hex, plain exit
    task automatic test_unsupported();
        drive_sys(32'd99, 32'h12345678, INSN_SYSCALL, 1'b1);
        expect_next(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 16'd1);
        clock_and_score("unsupported_99");
        drive_sys(32'h00010001, 32'h12345678, INSN_SYSCALL, 1'b1);
        expect_next(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 16'd2);
        clock_and_score("unsupported_upper");
        drive_sys(32'd4, 32'h10010000, INSN_SYSCALL, 1'b1);
        expect_next(1'b1, 2'd1, 32'h10010000, 1'b0, 32'h0, 1'b1, 16'd3);
        clock_and_score("print_str_err_sticky");
        drive_sys(32'd34, 32'hDEADBEEF, INSN_SYSCALL, 1'b1);
        expect_next(1'b1, 2'd3, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 16'd4);
        clock_and_score("print_hex_back_to_back");
        drive_sys(32'd10, 32'h0000002A, INSN_SYSCALL, 1'b1);
        expect_next(1'b0, 2'd3, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 16'd5);
        clock_and_score("exit_plain");
        drive_idle();
        expect_next(1'b0, 2'd3, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 16'd5);
        clock_and_score("halt_sticky");
    endtask

    task automatic test_saturation();
        drive_idle();
        rst = 1'b1;
        expect_next(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0);
        clock_and_score("sat_reset");
        rst = 1'b0;
        drive_sys(32'd34, 32'hCAFEF00D, INSN_SYSCALL, 1'b1);
        // 65534 unscored accepts bring the count to 16'hFFFE.
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
        end
        #1;
        expect_next(1'b1, 2'd3, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 16'hFFFF);
        clock_and_score("sat_reach_max");
        expect_next(1'b1, 2'd3, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 16'hFFFF);
        clock_and_score("sat_hold_max");
        drive_idle();
        expect_next(1'b0, 2'd3, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 16'hFFFF);
        clock_and_score("sat_idle");
    endtask

    task automatic test_reset_priority();
        drive_sys(32'd10, 32'h0, INSN_SYSCALL, 1'b1);
        rst = 1'b1;
        expect_next(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0);
        clock_and_score("rst_vs_exit");
        rst = 1'b0;
        drive_idle();
        expect_next(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0);
        clock_and_score("rst_vs_exit_after");
    endtask

    initial begin
        rst            = 1'b0;
        mem_to_reg_w   = 1'b0;
        read_data_w    = '0;
        alu_out_w      = '0;
        write_reg_w    = '0;
        a0             = '0;
        v0             = '0;
        instruction_in = '0;
        syscall_in     = 1'b0;
        @(negedge clk);

        test_reset();
        test_mux();
        test_print_and_exit();
        test_unsupported();
        test_saturation();
        test_reset_priority();

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
